can_ctrl_field_sequencer: RTL

//  Sequences reception of the CAN/CAN FD arbitration and control fields, one sampled bit per SP strobe.

---
 rtl/can_ctrl_field_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/can_ctrl_field_sequencer.sv
// Walks the CAN/CAN FD arbitration and control fields one destuffed bit at a time
// and registers ID, IDE, RTR, EDL, BRS, ESI, DLC plus a one-per-frame classification.
module can_ctrl_field_sequencer #(
  parameter logic ENABLE_FD = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sp_i,
  input  logic        rx_bit_i,
  input  logic        stuff_bit_i,
  input  logic        sof_i,
  input  logic        abort_i,
  output logic [28:0] id_o,
  output logic        ide_o,
  output logic        rtr_o,
  output logic        edl_o,
  output logic        brs_o,
  output logic        esi_o,
  output logic [3:0]  dlc_o,
  output logic [1:0]  frame_type_o,
  output logic        hdr_valid_o,
  output logic        busy_o,
  output logic        form_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_BID, S_R12, S_IDE, S_EID, S_ERTR, S_FDF,
    S_R0, S_RES, S_BRS, S_ESI, S_DLC, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [28:0] id_q, id_d;
  logic        ide_q, ide_d;
  logic        rtr_tmp_q, rtr_tmp_d;
  logic        edl_q, edl_d;
  logic        brs_q, brs_d;
  logic        esi_q, esi_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [1:0]  frame_type_q, frame_type_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        busy_q, busy_d;
  logic        form_err_q, form_err_d;
  logic        bit_ev;
  logic        fdf_bit;

  assign bit_ev  = sp_i & ~stuff_bit_i;
  // With FD disabled the FDF position is just a reserved bit.
  assign fdf_bit = rx_bit_i & ENABLE_FD;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      id_q         <= '0;
      ide_q        <= 1'b0;
      rtr_tmp_q    <= 1'b0;
      edl_q        <= 1'b0;
      brs_q        <= 1'b0;
      esi_q        <= 1'b0;
      dlc_q        <= '0;
      frame_type_q <= '0;
      hdr_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      form_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      id_q         <= id_d;
      ide_q        <= ide_d;
      rtr_tmp_q    <= rtr_tmp_d;
      edl_q        <= edl_d;
      brs_q        <= brs_d;
      esi_q        <= esi_d;
      dlc_q        <= dlc_d;
      frame_type_q <= frame_type_d;
      hdr_valid_q  <= hdr_valid_d;
      busy_q       <= busy_d;
      form_err_q   <= form_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    id_d         = id_q;
    ide_d        = ide_q;
    rtr_tmp_d    = rtr_tmp_q;
    edl_d        = edl_q;
    brs_d        = brs_q;
    esi_d        = esi_q;
    dlc_d        = dlc_q;
    frame_type_d = frame_type_q;
    hdr_valid_d  = 1'b0;
    busy_d       = busy_q;
    form_err_d   = 1'b0;

    // Priority: abort, then sof, then bit events.
    if (abort_i) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end else if (sof_i) begin
      state_d      = S_BID;
      bitcnt_d     = '0;
      id_d         = '0;
      ide_d        = 1'b0;
      rtr_tmp_d    = 1'b0;
      edl_d        = 1'b0;
      brs_d        = 1'b0;
      esi_d        = 1'b0;
      dlc_d        = '0;
      frame_type_d = '0;
      busy_d       = 1'b1;
    end else if (bit_ev) begin
      unique case (state_q)
        S_IDLE: ;
        S_BID: begin
          id_d[28:18] = {id_q[27:18], rx_bit_i};
          bitcnt_d    = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd10) state_d = S_R12;
        end
        S_R12: begin
          rtr_tmp_d = rx_bit_i;
          state_d   = S_IDE;
        end
        S_IDE: begin
          ide_d   = rx_bit_i;
          state_d = rx_bit_i ? S_EID : S_FDF;
        end
        S_EID: begin
          id_d[17:0] = {id_q[16:0], rx_bit_i};
          bitcnt_d   = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd17) state_d = S_ERTR;
        end
        S_ERTR: begin
          rtr_tmp_d = rx_bit_i;
          state_d   = S_FDF;
        end
        S_FDF: begin
          edl_d = fdf_bit;
          if (fdf_bit)    state_d = S_RES;
          else if (ide_q) state_d = S_R0;
          else            state_d = S_DLC;
        end
        S_R0: state_d = S_DLC;
        S_RES: begin
          if (rx_bit_i) begin
            form_err_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_BRS;
          end
        end
        S_BRS: begin
          brs_d   = rx_bit_i;
          state_d = S_ESI;
        end
        S_ESI: begin
          esi_d   = rx_bit_i;
          state_d = S_DLC;
        end
        S_DLC: begin
          dlc_d    = {dlc_q[2:0], rx_bit_i};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd3) begin
            state_d      = S_DONE;
            hdr_valid_d  = 1'b1;
            busy_d       = 1'b0;
            frame_type_d = edl_q ? 2'b10 : (rtr_tmp_q ? 2'b01 : 2'b00);
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end

    if (state_d != state_q) bitcnt_d = '0;
  end

  assign id_o         = id_q;
  assign ide_o        = ide_q;
  // The RRS position of an FD frame carries no remote request.
  assign rtr_o        = rtr_tmp_q & ~edl_q;
  assign edl_o        = edl_q;
  assign brs_o        = brs_q;
  assign esi_o        = esi_q;
  assign dlc_o        = dlc_q;
  assign frame_type_o = frame_type_q;
  assign hdr_valid_o  = hdr_valid_q;
  assign busy_o       = busy_q;
  assign form_err_o   = form_err_q;

endmodule
